// File: rtl/order_matcher_pkg.sv
// Shared definitions for the order matcher and the trade-counter bench.
package order_matcher_pkg;

    localparam int unsigned PRICE_W_DEF = 8;
    localparam int unsigned QTY_W_DEF   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        HALTED = 2'd2
    } state_t;

endpackage

// File: rtl/order_slot.sv
// One resting-order slot: load, decrement-with-clear, cancel.
module order_slot #(
    parameter int unsigned PRICE_W = 8,
    parameter int unsigned QTY_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [PRICE_W-1:0] load_price,
    input  logic [QTY_W-1:0]   load_qty,
    input  logic               dec,
    input  logic [QTY_W-1:0]   dec_qty,
    input  logic               cancel,
    output logic               valid,
    output logic [PRICE_W-1:0] price,
    output logic [QTY_W-1:0]   qty
);

    // Cancel outranks a fill; load only ever happens into an empty slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            price <= '0;
            qty   <= '0;
        end else if (cancel) begin
            valid <= 1'b0;
            qty   <= '0;
        end else if (dec) begin
            qty <= qty - dec_qty;
            if (qty == dec_qty) begin
                valid <= 1'b0;
            end
        end else if (load) begin
            valid <= (load_qty != '0);
            price <= load_price;
            qty   <= load_qty;
        end
    end

endmodule

// File: rtl/order_matcher.sv
// Single-pair order matcher: one bid, one ask, one fill pulse per trade.
module order_matcher
    import order_matcher_pkg::*;
#(
    parameter int unsigned PRICE_W = PRICE_W_DEF,
    parameter int unsigned QTY_W   = QTY_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               buy_valid,
    input  logic [PRICE_W-1:0] buy_price,
    input  logic [QTY_W-1:0]   buy_qty,
    output logic               buy_ready,
    input  logic               sell_valid,
    input  logic [PRICE_W-1:0] sell_price,
    input  logic [QTY_W-1:0]   sell_qty,
    output logic               sell_ready,
    input  logic               cancel_bid,
    input  logic               cancel_ask,
    input  logic               halt_signal,
    output logic               match_signal,
    output logic [PRICE_W-1:0] match_price,
    output logic [QTY_W-1:0]   match_qty,
    output logic               enable_count,
    output logic               bid_valid,
    output logic               ask_valid
);

    state_t             state;
    logic [PRICE_W-1:0] bid_price;
    logic [PRICE_W-1:0] ask_price;
    logic [QTY_W-1:0]   bid_qty;
    logic [QTY_W-1:0]   ask_qty;
    logic [QTY_W-1:0]   fill_qty;
    logic               crossed;
    logic               cancel_en;
    logic               fire;

    assign buy_ready  = !bid_valid && (state == IDLE);
    assign sell_ready = !ask_valid && (state == IDLE);
    assign crossed    = bid_valid && ask_valid && (bid_price >= ask_price);
    assign cancel_en  = (state != FILL);
    assign fill_qty   = (bid_qty < ask_qty) ? bid_qty : ask_qty;
    // A halt or any cancel in the decision cycle suppresses the fill.
    assign fire       = (state == IDLE) && crossed && !halt_signal
                        && !cancel_bid && !cancel_ask;

    order_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_bid (
        .clk        (clk),
        .reset      (reset),
        .load       (buy_valid && buy_ready),
        .load_price (buy_price),
        .load_qty   (buy_qty),
        .dec        (fire),
        .dec_qty    (fill_qty),
        .cancel     (cancel_bid && cancel_en),
        .valid      (bid_valid),
        .price      (bid_price),
        .qty        (bid_qty)
    );

    order_slot #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) u_ask (
        .clk        (clk),
        .reset      (reset),
        .load       (sell_valid && sell_ready),
        .load_price (sell_price),
        .load_qty   (sell_qty),
        .dec        (fire),
        .dec_qty    (fill_qty),
        .cancel     (cancel_ask && cancel_en),
        .valid      (ask_valid),
        .price      (ask_price),
        .qty        (ask_qty)
    );

    // Control FSM; FILL is a one-cycle cooldown after each pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            match_signal <= 1'b0;
            match_price  <= '0;
            match_qty    <= '0;
            enable_count <= 1'b1;
        end else if (halt_signal) begin
            state        <= HALTED;
            match_signal <= 1'b0;
            enable_count <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        state        <= FILL;
                        match_signal <= 1'b1;
                        match_price  <= ask_price;
                        match_qty    <= fill_qty;
                    end
                end
                FILL: begin
                    state        <= IDLE;
                    match_signal <= 1'b0;
                end
                HALTED: begin
                    state        <= HALTED;
                    match_signal <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    match_signal <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_order_matcher.sv
// Scoreboard bench for order_matcher with a behavioural order-book model.
module tb_order_matcher;
    import order_matcher_pkg::*;

    localparam int unsigned PW = PRICE_W_DEF;
    localparam int unsigned QW = QTY_W_DEF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          buy_valid = 1'b0, sell_valid = 1'b0;
    logic [PW-1:0] buy_price = '0, sell_price = '0;
    logic [QW-1:0] buy_qty = '0, sell_qty = '0;
    logic          cancel_bid = 1'b0, cancel_ask = 1'b0, halt_signal = 1'b0;
    logic          buy_ready, sell_ready, match_signal, enable_count;
    logic          bid_valid, ask_valid;
    logic [PW-1:0] match_price;
    logic [QW-1:0] match_qty;

    order_matcher dut (
        .clk(clk), .reset(reset),
        .buy_valid(buy_valid), .buy_price(buy_price), .buy_qty(buy_qty), .buy_ready(buy_ready),
        .sell_valid(sell_valid), .sell_price(sell_price), .sell_qty(sell_qty), .sell_ready(sell_ready),
        .cancel_bid(cancel_bid), .cancel_ask(cancel_ask), .halt_signal(halt_signal),
        .match_signal(match_signal), .match_price(match_price), .match_qty(match_qty),
        .enable_count(enable_count), .bid_valid(bid_valid), .ask_valid(ask_valid)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; int unsigned p; int unsigned q; } book_t;
    typedef struct { int unsigned p; int unsigned q; } fill_t;

    fill_t       exp_q[$];
    book_t       m_bid = '{0, 0, 0};
    book_t       m_ask = '{0, 0, 0};
    bit          m_cool = 0, m_halted = 0, m_sig = 0;
    int unsigned m_price = 0, m_qty = 0;
    int          tests = 0, fails = 0;

    task automatic check(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference book: bid/ask as records, fills computed from the trading rules.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_bid = '{0, 0, 0};
            m_ask = '{0, 0, 0};
            m_cool = 0; m_halted = 0; m_sig = 0;
            m_price = 0; m_qty = 0;
            exp_q.delete();
        end else begin
            bit b_rdy, a_rdy, trade, live;
            int unsigned q;
            live  = !m_cool && !m_halted;
            b_rdy = !m_bid.v && live;
            a_rdy = !m_ask.v && live;
            trade = live && m_bid.v && m_ask.v && (m_bid.p >= m_ask.p)
                    && !halt_signal && !cancel_bid && !cancel_ask;
            if (trade) begin
                q = (m_bid.q < m_ask.q) ? m_bid.q : m_ask.q;
                exp_q.push_back('{m_ask.p, q});
                m_price = m_ask.p;
                m_qty   = q;
                m_bid.q = m_bid.q - q;
                m_ask.q = m_ask.q - q;
                if (m_bid.q == 0) m_bid.v = 0;
                if (m_ask.q == 0) m_ask.v = 0;
            end
            if (cancel_bid && !m_cool) m_bid = '{0, 0, 0};
            else if (buy_valid && b_rdy && buy_qty != 0) m_bid = '{1, buy_price, buy_qty};
            if (cancel_ask && !m_cool) m_ask = '{0, 0, 0};
            else if (sell_valid && a_rdy && sell_qty != 0) m_ask = '{1, sell_price, sell_qty};
            m_sig  = trade;
            m_cool = trade;
            if (halt_signal) begin
                m_halted = 1;
                m_cool   = 0;
            end
        end
    end

    // Monitor: pops the scoreboard on every pulse and tracks visible state.
    always @(negedge clk) begin
        fill_t f;
        check("match_signal", match_signal, m_sig);
        if (match_signal) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pulse: got pulse expected none at %0t", $time);
            end else begin
                f = exp_q.pop_front();
                check("pulse_price", match_price, f.p);
                check("pulse_qty", match_qty, f.q);
            end
        end
        check("bid_valid", bid_valid, m_bid.v);
        check("ask_valid", ask_valid, m_ask.v);
        check("buy_ready", buy_ready, !m_bid.v && !m_cool && !m_halted);
        check("sell_ready", sell_ready, !m_ask.v && !m_cool && !m_halted);
        check("enable_count", enable_count, !m_halted);
        check("held_price", match_price, m_price);
        check("held_qty", match_qty, m_qty);
    end

    task automatic drive(bit bv, int bp, int bq, bit sv, int sp, int sq, bit cb, bit ca, bit h);
        @(negedge clk);
        buy_valid = bv;  buy_price = PW'(bp);  buy_qty = QW'(bq);
        sell_valid = sv; sell_price = PW'(sp); sell_qty = QW'(sq);
        cancel_bid = cb; cancel_ask = ca; halt_signal = h;
    endtask

    task automatic idle(int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        check("rst_enable_count", enable_count, 1);
        check("rst_match_signal", match_signal, 0);
        @(negedge clk) reset = 1'b0;

        // full fill
        drive(1, 10, 50, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 9, 50, 0, 0, 0);
        idle(3);
        check("full_price", match_price, 9);
        check("full_qty", match_qty, 50);
        check("full_bid_empty", bid_valid, 0);
        check("full_buy_ready", buy_ready, 1);

        // partial fill then residual cross
        drive(1, 20, 30, 1, 20, 10, 0, 0, 0);
        idle(3);
        check("part1_qty", match_qty, 10);
        check("part1_bid_left", bid_valid, 1);
        drive(0, 0, 0, 1, 18, 25, 0, 0, 0);
        idle(3);
        check("part2_price", match_price, 18);
        check("part2_qty", match_qty, 20);
        check("part2_ask_left", ask_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // no cross then cancel
        drive(1, 7, 5, 1, 8, 5, 0, 0, 0);
        idle(10);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        check("nc_bid_cleared", bid_valid, 0);
        check("nc_buy_ready", buy_ready, 1);
        check("nc_ask_kept", ask_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);

        // zero qty and cancel priority
        drive(1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        check("zero_qty_empty", bid_valid, 0);
        drive(1, 10, 10, 1, 10, 10, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(1);
        check("cp_no_pulse", match_signal, 0);
        check("cp_ask_cleared", ask_valid, 0);
        check("cp_bid_kept", bid_valid, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // reset during a pulse
        drive(1, 6, 4, 1, 6, 4, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin
            idle(1);
            seen = match_signal;
        end
        check("pulse_before_reset", seen, 1);
        #2 reset = 1'b1;
        #1;
        check("rr_match_signal", match_signal, 0);
        check("rr_match_price", match_price, 0);
        check("rr_match_qty", match_qty, 0);
        check("rr_bid_valid", bid_valid, 0);
        check("rr_ask_valid", ask_valid, 0);
        check("rr_enable_count", enable_count, 1);
        @(negedge clk) reset = 1'b0;
        drive(1, 5, 3, 1, 5, 3, 0, 0, 0);
        idle(3);
        check("post_reset_price", match_price, 5);
        check("post_reset_qty", match_qty, 3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit bv, sv;
            bv = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 2) == 0);
            drive(bv, $urandom_range(0, 15), $urandom_range(0, 7),
                  sv, $urandom_range(0, 15), $urandom_range(0, 7),
                  !bv && ($urandom_range(0, 11) == 0),
                  !sv && ($urandom_range(0, 11) == 0), 0);
        end

        // halt on a crossing decision cycle
        repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 1, 0);
        idle(1);
        drive(1, 9, 8, 1, 9, 8, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        check("halt_no_pulse", match_signal, 0);
        check("halt_enable_count", enable_count, 0);
        check("halt_buy_ready", buy_ready, 0);
        check("halt_sell_ready", sell_ready, 0);
        check("halt_bid_kept", bid_valid, 1);
        check("halt_ask_kept", ask_valid, 1);
        idle(4);
        check("halt_sticky", enable_count, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
